// File: rtl/conv_state_pkg.sv
// Shared phase encodings and layer defaults for the conv sequencer
// and the conv controller that consumes current_state.
package conv_state_pkg;

    typedef enum logic [2:0] {
        ST_INIT = 3'b000,
        ST_A    = 3'b001,
        ST_B    = 3'b010,
        ST_C    = 3'b011,
        ST_DONE = 3'b100,
        ST_ERR  = 3'b101
    } conv_state_e;

    localparam int ROW_NUM_DEF     = 9;
    localparam int TIMEOUT_DEF     = 1023;
    localparam int CNT_WIDTH_DEF   = 10;

    function automatic logic is_busy(conv_state_e s);
        return (s == ST_A) || (s == ST_B) || (s == ST_C);
    endfunction

endpackage

// File: rtl/phase_watchdog.sv
// Per-phase cycle counter; expired flags that the current phase
// has lasted TIMEOUT_CYCLES cycles without being cleared.
module phase_watchdog
    import conv_state_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
    parameter int CNT_WIDTH      = CNT_WIDTH_DEF
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    assign expired = (cnt_q == LIMIT);

    // Hold at the limit so the count can never wrap back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/conv_state_seq.sv
// Layer sequencer: walks A->B->C once per row for ROW_NUM rows,
// with a per-phase watchdog and an abort path back to INIT.
module conv_state_seq
    import conv_state_pkg::*;
#(
    parameter int ROW_NUM        = ROW_NUM_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
    parameter int CNT_WIDTH      = CNT_WIDTH_DEF
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic       abort,
    input  logic       state_rst,
    output logic [2:0] current_state,
    output logic [3:0] row_idx,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [3:0] LAST_ROW = 4'(ROW_NUM - 1);

    conv_state_e state_q;
    conv_state_e state_d;
    logic [3:0]  row_q;
    logic [3:0]  row_d;
    logic        err_q;
    logic        err_d;
    logic        wd_clr;
    logic        wd_expired;

    assign current_state = state_q;
    assign row_idx       = row_q;
    assign busy          = is_busy(state_q);
    assign done          = (state_q == ST_DONE);
    assign err           = err_q;

    // Every state change, including abort, restarts the phase timer.
    assign wd_clr = abort || (state_d != state_q);

    phase_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_WIDTH      (CNT_WIDTH)
    ) u_wd (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (wd_clr),
        .en      (busy),
        .expired (wd_expired)
    );

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        err_d   = err_q;
        if (abort) begin
            state_d = ST_INIT;
            row_d   = '0;
            err_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_INIT: begin
                    if (start) begin
                        state_d = ST_A;
                        row_d   = '0;
                    end
                end
                ST_A: begin
                    if (state_rst) begin
                        state_d = ST_B;
                    end else if (wd_expired) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end
                end
                ST_B: begin
                    if (state_rst) begin
                        state_d = ST_C;
                    end else if (wd_expired) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end
                end
                ST_C: begin
                    if (state_rst) begin
                        if (row_q < LAST_ROW) begin
                            state_d = ST_A;
                            row_d   = row_q + 1'b1;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else if (wd_expired) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end
                end
                ST_DONE: state_d = ST_INIT;
                ST_ERR:  state_d = ST_ERR;
                default: state_d = ST_INIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_INIT;
            row_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_conv_state_seq.sv
// Directed bench for conv_state_seq with default parameters.
module tb_conv_state_seq;

    localparam logic [31:0] S_INIT = 32'd0;
    localparam logic [31:0] S_A    = 32'd1;
    localparam logic [31:0] S_B    = 32'd2;
    localparam logic [31:0] S_C    = 32'd3;
    localparam logic [31:0] S_DONE = 32'd4;
    localparam logic [31:0] S_ERR  = 32'd5;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       state_rst = 1'b0;
    logic [2:0] current_state;
    logic [3:0] row_idx;
    logic       busy;
    logic       done;
    logic       err;

    int errors = 0;
    int checks = 0;

    conv_state_seq dut (
        .clk           (clk),
        .rstn          (rstn),
        .start         (start),
        .abort         (abort),
        .state_rst     (state_rst),
        .current_state (current_state),
        .row_idx       (row_idx),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int n);
        for (int i = 0; i < n; i++) begin
            state_rst = 1'b1;
            step();
            state_rst = 1'b0;
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] st,
                           input logic [31:0] row, input logic [31:0] bz,
                           input logic [31:0] dn, input logic [31:0] er);
        chk({tag, "_state"}, 32'(current_state), st);
        chk({tag, "_row"}, 32'(row_idx), row);
        chk({tag, "_busy"}, 32'(busy), bz);
        chk({tag, "_done"}, 32'(done), dn);
        chk({tag, "_err"}, 32'(err), er);
    endtask

    initial begin
        #12;
        chk_all("reset", S_INIT, 0, 0, 0, 0);
        @(negedge clk);
        rstn = 1'b1;
        step();
        chk_all("idle", S_INIT, 0, 0, 0, 0);

        // Full layer: 27 phases, then DONE, then INIT.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int r = 0; r < 9; r++) begin
            for (int p = 1; p <= 3; p++) begin
                chk("layer_state", 32'(current_state), 32'(p));
                chk("layer_row", 32'(row_idx), 32'(r));
                chk("layer_busy", 32'(busy), 32'd1);
                pulse(1);
            end
        end
        chk_all("done", S_DONE, 8, 0, 1, 0);
        step();
        chk_all("post_done", S_INIT, 8, 0, 0, 0);
        pulse(1);
        chk("ignore_rst_init", 32'(current_state), S_INIT);

        // state_rst held for three cycles.
        start = 1'b1;
        step();
        start = 1'b0;
        chk_all("held_a", S_A, 0, 1, 0, 0);
        state_rst = 1'b1;
        step();
        chk("held_b", 32'(current_state), S_B);
        step();
        chk("held_c", 32'(current_state), S_C);
        step();
        state_rst = 1'b0;
        chk_all("held_a1", S_A, 1, 1, 0, 0);

        // state_rst exactly on the timeout cycle wins.
        repeat (1023) step();
        chk_all("pre_to_a", S_A, 1, 1, 0, 0);
        pulse(1);
        chk_all("to_rst_wins", S_B, 1, 1, 0, 0);

        // Timeout in B.
        repeat (1023) step();
        chk_all("pre_to_b", S_B, 1, 1, 0, 0);
        step();
        chk_all("timeout", S_ERR, 1, 0, 0, 1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk_all("err_start", S_ERR, 1, 0, 0, 1);
        pulse(1);
        chk_all("err_rst", S_ERR, 1, 0, 0, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk_all("err_abort", S_INIT, 0, 0, 0, 0);

        // Start during busy, then abort with state_rst in C.
        start = 1'b1;
        step();
        start = 1'b0;
        pulse(6);
        chk_all("pre_start_busy", S_A, 2, 1, 0, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk_all("start_busy", S_A, 2, 1, 0, 0);
        pulse(2);
        chk_all("in_c", S_C, 2, 1, 0, 0);
        abort = 1'b1;
        state_rst = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        state_rst = 1'b0;
        start = 1'b0;
        chk_all("abort_c", S_INIT, 0, 0, 0, 0);

        // Asynchronous reset mid-cycle while in C, row 5.
        start = 1'b1;
        step();
        start = 1'b0;
        pulse(17);
        chk_all("c_row5", S_C, 5, 1, 0, 0);
        #2;
        rstn = 1'b0;
        #1;
        chk_all("async_rst", S_INIT, 0, 0, 0, 0);
        @(negedge clk);
        rstn = 1'b1;
        step();
        step();
        chk_all("after_rst", S_INIT, 0, 0, 0, 0);
        pulse(1);
        chk_all("after_rst_rst", S_INIT, 0, 0, 0, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk_all("restart", S_A, 0, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_state_seq.md
CONV_STATE_SEQ -- requirements
Module: conv_state_seq

Interface
REQ-001 SHALL have parameter ROW_NUM, default 9: A->B->C passes per layer.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1023: maximum cycles allowed in one phase without state_rst.
REQ-003 SHALL have parameter CNT_WIDTH, default 10: width of the phase watchdog counter; must satisfy 2^CNT_WIDTH > TIMEOUT_CYCLES.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port rstn, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1: one-cycle layer-start request.
REQ-007 SHALL have port abort, input, 1: synchronous return to INIT.
REQ-008 SHALL have port state_rst, input, 1: phase-complete pulse from the conv controller.
REQ-009 SHALL have port current_state, output, 3: registered phase code driven to the conv controller.
REQ-010 SHALL have port row_idx, output, 4: current pass index, 0..ROW_NUM-1.
REQ-011 SHALL have port busy, output, 1: high in A, B or C.
REQ-012 SHALL have port done, output, 1: one-cycle pulse at layer end.
REQ-013 SHALL have port err, output, 1: sticky watchdog timeout flag.

Function
REQ-014 SHALL use state encodings INIT=000, A=001, B=010, C=011, DONE=100, ERR=101; current_state SHALL be the state register itself.
REQ-015 INIT: start=1 SHALL transition to A next cycle and clear row_idx to 0.
REQ-016 In A, B or C: state_rst=1 SHALL advance the state next cycle, A->B, B->C.
REQ-017 In C with state_rst=1: if row_idx<ROW_NUM-1, SHALL go to A and increment row_idx; else SHALL go to DONE.
REQ-018 DONE SHALL last exactly one cycle with done=1, then go to INIT; row_idx SHALL hold its final value until the next start.
REQ-019 state_rst SHALL be ignored in INIT, DONE and ERR.
REQ-020 start SHALL be ignored in every state except INIT.
REQ-021 Latency: a state_rst sampled at edge n SHALL be reflected in current_state after edge n (one cycle).
REQ-022 The watchdog counter SHALL clear on every state change and increment each cycle in A, B or C.
REQ-023 When the watchdog count reaches TIMEOUT_CYCLES with no state_rst in that cycle, the FSM SHALL go to ERR and set err.
REQ-024 If state_rst and timeout coincide, state_rst SHALL win and no error SHALL be raised.
REQ-025 ERR SHALL hold until abort or reset; err SHALL remain 1 in ERR.
REQ-026 abort=1 SHALL force INIT next cycle from any state, clear err, row_idx and the watchdog, and override start and state_rst in the same cycle.
REQ-027 busy SHALL be decoded combinationally from the state register (A, B or C); done SHALL be high only in DONE.

Reset
REQ-028 rstn low SHALL asynchronously force current_state=INIT, row_idx=0, watchdog=0, err=0, busy=0 and done=0.
REQ-029 Reset deassertion mid-operation SHALL resume in INIT and wait for a fresh start; no phase SHALL be resumed.

Structure
REQ-030 State encodings, ROW_NUM default and TIMEOUT_CYCLES default SHALL live in the shared package conv_state_pkg, imported by both this block and the conv controller.
REQ-031 The watchdog SHALL be the one sub-module, phase_watchdog, with inputs clr and en and output expired; everything else SHALL be flat.

Verification
REQ-032 Reset, then start, then 27 state_rst pulses with ROW_NUM=9 -> current_state sequence A,B,C repeated 9 times with row_idx 0..8, then DONE for 1 cycle with done=1, then INIT.
REQ-033 state_rst held high for 3 consecutive cycles from A -> states B, C, A on successive cycles with row_idx=1.
REQ-034 In B, no state_rst for 1023 cycles -> ERR and err=1 on the next cycle; a later start is ignored; abort -> INIT with err=0.
REQ-035 state_rst asserted exactly on the timeout cycle -> advance to the next phase with err staying 0.
REQ-036 abort and state_rst in the same cycle in C -> INIT with row_idx=0; start pulsed during busy -> no effect.
REQ-037 rstn asserted low asynchronously mid-clock while in C with row_idx=5 -> all outputs cleared before the next edge; after release the block stays in INIT until start.
